// File: rtl/reorder_request_scheduler_pkg.sv
// Shared types and helpers for the reorder-queue request scheduler.
// log2(n) returns the number of bits needed to hold the value n (at least 1).
package reorder_request_scheduler_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } sched_state_e;

    function automatic int log2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if (n >= (1 << i)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/reorder_request_scheduler_rr_arbiter.sv
// Round-robin arbiter: the lowest requesting index at or after ptr_i wins, wrapping at NUM_REQ.
// NUM_REQ is a power of two, so the wrap is plain modular addition on SRC_WIDTH bits.
module reorder_request_scheduler_rr_arbiter
    import reorder_request_scheduler_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int SRC_WIDTH = log2(NUM_REQ - 1)
) (
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [SRC_WIDTH-1:0] ptr_i,
    input  logic                 enable_i,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic [SRC_WIDTH-1:0] idx_o
);

    always_comb begin
        logic                 found;
        logic [SRC_WIDTH-1:0] cand;
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = ptr_i + SRC_WIDTH'(i);
            if (!found && req_i[cand]) begin
                found = 1'b1;
                idx_o = cand;
            end
        end
        if (enable_i && found) begin
            grant_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/reorder_request_scheduler.sv
// Issues requester reads onto one memory port, tagging each with the reorder queue's next index.
// Tracks outstanding requests and supports a drain handshake for quiescing.
module reorder_request_scheduler
    import reorder_request_scheduler_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_WIDTH  = 48,
    parameter int DEPTH       = 64,
    parameter int TAG_WIDTH   = log2(DEPTH - 1) + 1,
    parameter int INIT_CYCLES = DEPTH + 2,
    parameter int SRC_WIDTH   = log2(NUM_REQ - 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [TAG_WIDTH-1:0]          rq_index_tag,
    input  logic                          rq_full,
    output logic                          rq_increment,
    input  logic                          rq_valid,
    output logic                          mem_valid,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [TAG_WIDTH-1:0]          mem_tag,
    output logic [SRC_WIDTH-1:0]          mem_src,
    input  logic                          mem_stall,
    input  logic                          drain,
    output logic                          drained,
    output logic [TAG_WIDTH-1:0]          outstanding
);

    localparam int CNT_W = log2(INIT_CYCLES);

    sched_state_e          state_q, state_d;
    logic [CNT_W-1:0]      init_cnt_q, init_cnt_d;
    logic [SRC_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
    logic                  mem_valid_q, mem_valid_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [TAG_WIDTH-1:0]  mem_tag_q, mem_tag_d;
    logic [SRC_WIDTH-1:0]  mem_src_q, mem_src_d;
    logic [TAG_WIDTH-1:0]  outstanding_q, outstanding_d;

    logic                  slot_free;
    logic                  can_issue;
    logic [NUM_REQ-1:0]    grant;
    logic [SRC_WIDTH-1:0]  grant_idx;

    // Gating on rst keeps a grant from slipping out while the queue itself is being reset.
    assign slot_free = !mem_valid_q || !mem_stall;
    assign can_issue = !rst && (state_q == ST_RUN) && slot_free && !rq_full && !drain
                       && (|req_valid);

    reorder_request_scheduler_rr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .SRC_WIDTH (SRC_WIDTH)
    ) u_arb (
        .req_i    (req_valid),
        .ptr_i    (rr_ptr_q),
        .enable_i (can_issue),
        .grant_o  (grant),
        .idx_o    (grant_idx)
    );

    assign req_ready    = grant;
    assign rq_increment = can_issue;
    assign mem_valid    = mem_valid_q;
    assign mem_addr     = mem_addr_q;
    assign mem_tag      = mem_tag_q;
    assign mem_src      = mem_src_q;
    assign outstanding  = outstanding_q;
    assign drained      = (state_q == ST_RUN) && (outstanding_q == '0) && !mem_valid_q && drain;

    always_comb begin
        state_d       = state_q;
        init_cnt_d    = init_cnt_q;
        rr_ptr_d      = rr_ptr_q;
        mem_valid_d   = mem_valid_q;
        mem_addr_d    = mem_addr_q;
        mem_tag_d     = mem_tag_q;
        mem_src_d     = mem_src_q;
        outstanding_d = outstanding_q;

        // The counter reaching zero and the move to RUN happen on the same edge.
        case (state_q)
            ST_INIT: begin
                if (init_cnt_q <= CNT_W'(1)) begin
                    state_d = ST_RUN;
                end
                if (init_cnt_q != '0) begin
                    init_cnt_d = init_cnt_q - CNT_W'(1);
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase

        if (mem_valid_q && mem_stall) begin
            mem_valid_d = 1'b1;
        end else if (can_issue) begin
            mem_valid_d = 1'b1;
            mem_addr_d  = req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
            mem_tag_d   = rq_index_tag;
            mem_src_d   = grant_idx;
            rr_ptr_d    = grant_idx + SRC_WIDTH'(1);
        end else begin
            mem_valid_d = 1'b0;
        end

        case ({rq_increment, rq_valid})
            2'b10:   outstanding_d = outstanding_q + TAG_WIDTH'(1);
            2'b01:   outstanding_d = outstanding_q - TAG_WIDTH'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_INIT;
            init_cnt_q    <= CNT_W'(INIT_CYCLES);
            rr_ptr_q      <= '0;
            mem_valid_q   <= 1'b0;
            mem_addr_q    <= '0;
            mem_tag_q     <= '0;
            mem_src_q     <= '0;
            outstanding_q <= '0;
        end else begin
            state_q       <= state_d;
            init_cnt_q    <= init_cnt_d;
            rr_ptr_q      <= rr_ptr_d;
            mem_valid_q   <= mem_valid_d;
            mem_addr_q    <= mem_addr_d;
            mem_tag_q     <= mem_tag_d;
            mem_src_q     <= mem_src_d;
            outstanding_q <= outstanding_d;
        end
    end

    a_no_increment_when_full: assert property (@(posedge clk) disable iff (rst)
        !(rq_increment && rq_full))
        else $fatal(1, "rq_increment asserted while rq_full");

endmodule

// File: doc/reorder_request_scheduler.md
# reorder_request_scheduler

Front-end controller for the reorder queue: round-robin arbitration of NUM_REQ read requesters onto one memory request port, allocating a reorder tag per issued request. Tags come from the queue's `index_tag`/`increment` pair, so the queue never overflows and responses return in issue order. It also counts outstanding requests and supports a drain handshake for quiescing before reconfiguration.

## Interface
- NUM_REQ, 4, number of requesters (≥2, power of two)
- ADDR_WIDTH, 48, request address width
- DEPTH, 64, reorder queue depth; must match the queue instance
- TAG_WIDTH, log2(DEPTH-1)+1, tag width including wrap bit
- INIT_CYCLES, DEPTH+2, post-reset wait for queue initialisation
- SRC_WIDTH, log2(NUM_REQ-1), requester-index width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NUM_REQ  per-requester request pending
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_ready  out  NUM_REQ  one-hot grant; request consumed this cycle
- rq_index_tag  in  TAG_WIDTH  next tag from queue
- rq_full  in  1  queue full
- rq_increment  out  1  allocate tag this cycle
- rq_valid  in  1  queue retired one entry
- mem_valid  out  1  request on memory port
- mem_addr  out  ADDR_WIDTH  request address
- mem_tag  out  TAG_WIDTH  tag; memory returns it in the response index field
- mem_src  out  SRC_WIDTH  granted requester index
- mem_stall  in  1  memory back-pressure; holds current request
- drain  in  1  stop granting new requests
- drained  out  1  no requests outstanding and port empty
- outstanding  out  TAG_WIDTH  issued minus retired count

## Operation
- States: INIT, RUN. rst forces INIT and loads the init counter with INIT_CYCLES. INIT decrements each cycle and moves to RUN when the counter is 0. No grants occur in INIT.
- Slot free when `!mem_valid || !mem_stall`.
- can_issue = RUN && slot free && !rq_full && !drain && |req_valid.
- Round-robin: search starts at rr_ptr, lowest index at or after rr_ptr with req_valid set wins, wrapping at NUM_REQ. On a grant to g, rr_ptr ← (g+1) mod NUM_REQ. Otherwise rr_ptr holds.
- On grant (all combinational, same cycle):
  - req_ready[g]=1
  - rq_increment=1
- On the next edge after a grant: mem_addr←req_addr[g], mem_tag←rq_index_tag, mem_src←g, mem_valid←1.
- Slot free with no grant: mem_valid←0 at next edge.
- mem_valid && mem_stall: all mem_* hold exactly.
- outstanding: +1 on rq_increment, −1 on rq_valid, unchanged if both. Never exceeds DEPTH.
- drained = RUN && outstanding==0 && !mem_valid && drain.
- rq_increment while rq_full is forbidden. A simulation-only check reports an error and finishes.

## Timing
- Reset values: req_ready=0, rq_increment=0, mem_valid=0, mem_addr=0, mem_tag=0, mem_src=0, outstanding=0, drained=0, rr_ptr=0, state INIT.
- First grant possible INIT_CYCLES+1 cycles after rst deasserts.
- Grant-to-mem_valid latency: 1 cycle. With no stall, throughput is 1 request/cycle.
- rq_full, mem_stall, drain and req_valid are all combinational into grant; no registered delay.
- rst mid-operation: mem_valid drops next cycle and the pending request is discarded. The queue is reset by the same rst.
- Drain asserted with a stalled request: that request is still delivered. drained rises the cycle after the last rq_valid.

## Structure
- Shared package/header (`reorder_pkg.vh`): state encodings (INIT, RUN) and the log2 function (`log2.vh`).
- Sub-module `rr_arbiter` (NUM_REQ): inputs req, ptr, enable; outputs one-hot grant and encoded index. The scheduler owns the rr_ptr register, the output register, the counters and the FSM.

## Test plan
- Reset and init: rst 1 cycle, req_valid=4'b1111 → no req_ready for 66 cycles (DEPTH=64); first grant to requester 0 with mem_tag = rq_index_tag.
- Round-robin fairness: all 4 requesting continuously, no stall → mem_src sequence 0,1,2,3,0…; tags consecutive; outstanding increments by 1/cycle.
- Back-pressure: mem_stall high 3 cycles during traffic → mem_addr/mem_tag/mem_src stable for those 3 cycles, no req_ready, rq_increment low; resumes next cycle.
- Full queue: issue 64 with no retirement → rq_full, grants stop, outstanding=64, no overflow error; one rq_valid → exactly one further grant.
- Sparse requesters: only requester 2 valid, rr_ptr=3 → grant 2 (wraparound search), rr_ptr becomes 3.
- Drain: drain=1 with 5 outstanding → no new grants; drained=1 exactly one cycle after the 5th rq_valid; rst mid-traffic → mem_valid=0 and outstanding=0 next cycle.
